transform_scheduler: RTL
========================

TRANSFORM_SCHEDULER -- requirements
Module: transform_scheduler

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 4, meaning the register-stage count of the transform/quant/invquant/invtran datapath it sequences.
REQ-002 SHALL have parameter BLOCKS, default 16, meaning the number of 4x4 blocks per macroblock.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port mb_start  input  1  meaning a macroblock start request, sampled only in IDLE.
REQ-006 SHALL have port mb_abort  input  1  meaning a synchronous flush of the current macroblock.
REQ-007 SHALL have port mb_busy  output  1  meaning state is not IDLE.
REQ-008 SHALL have port mb_done  output  1  meaning a one-cycle pulse when all BLOCKS results have retired.
REQ-009 SHALL have port res_valid  input  1  meaning the residual source presents a block.
REQ-010 SHALL have port res_ready  output  1  meaning the scheduler accepts the block this cycle.
REQ-011 SHALL have port res_blk_idx  output  4  meaning the index (0..BLOCKS-1) of the next block requested.
REQ-012 SHALL have port dp_enable  output  1  meaning the enable to every datapath stage.
REQ-013 SHALL have port out_valid  output  1  meaning a reconstructed block is at the datapath tail.
REQ-014 SHALL have port out_blk_idx  output  4  meaning the index of the block at the tail.
REQ-015 SHALL have port out_ready  input  1  meaning the sink accepts the tail block.
REQ-016 SHALL have port inflight  output  3  meaning the count of valid pipeline slots, 0..PIPE_LAT.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 SHALL transition IDLE->RUN on mb_start, clearing issued and retired counters; mb_start in any other state SHALL be ignored.
REQ-019 SHALL transition RUN->DRAIN on the accept that makes issued equal BLOCKS.
REQ-020 SHALL transition DRAIN->DONE on the output handshake that makes retired equal BLOCKS.
REQ-021 SHALL transition DONE->IDLE unconditionally after one cycle, with mb_done=1 only in DONE.
REQ-022 SHALL track a PIPE_LAT-entry shift register of {valid, idx} mirroring the datapath; the tail is entry PIPE_LAT-1.
REQ-023 SHALL assert out_valid equal to tail valid and drive out_blk_idx from the tail idx.
REQ-024 SHALL drive dp_enable=1 in RUN or DRAIN unless (out_valid and not out_ready); otherwise 0.
REQ-025 SHALL shift the register only when dp_enable=1, loading entry0 with {accept, res_blk_idx}, so a cycle with no accept inserts a bubble.
REQ-026 SHALL drive res_ready = (state==RUN) and (issued<BLOCKS) and dp_enable; accept = res_valid and res_ready.
REQ-027 SHALL increment issued (and res_blk_idx) on accept, and increment retired on out_valid and out_ready.
REQ-028 SHALL present a block accepted in cycle N on out_valid in cycle N+PIPE_LAT when no stall occurs; each stall cycle adds one cycle.
REQ-029 SHALL hold the entire shift register, counters and res_blk_idx unchanged during a stall.
REQ-030 SHALL drive inflight as the popcount of valid entries.
REQ-031 SHALL, on mb_abort in any state, clear all valid bits and counters and enter IDLE next cycle without pulsing mb_done; mb_abort SHALL take priority over mb_start, accept and retire in the same cycle.
REQ-032 SHALL keep res_ready=0 and dp_enable=0 in IDLE and DONE.

Reset
REQ-033 SHALL, while reset=0, immediately force state IDLE, all valid bits 0, issued=retired=0, res_blk_idx=0, and outputs mb_busy=0, mb_done=0, res_ready=0, dp_enable=0, out_valid=0, out_blk_idx=0, inflight=0, including mid-macroblock.

Verification
REQ-034 SHALL cover: mb_start with res_valid and out_ready held 1 -> indices 0..15 accepted on 16 consecutive cycles, out_valid first at accept+4, mb_done one cycle after idx 15 retires.
REQ-035 SHALL cover: out_ready=0 for 3 cycles while idx 2 is at the tail -> dp_enable=0, res_ready=0 and out_blk_idx held at 2 for 3 cycles, with no index lost or duplicated.
REQ-036 SHALL cover: res_valid toggling 1,0,1 -> bubble propagates, inflight reads 1,1,2 and outputs retain idx order 0,1.
REQ-037 SHALL cover: mb_abort asserted with inflight=3 and mb_start in the same cycle -> IDLE next cycle, inflight=0, no mb_done, mb_start ignored.
REQ-038 SHALL cover: reset driven low mid-RUN between clock edges -> all outputs zero before the next edge, and a fresh mb_start after release restarts at idx 0.

Source files
------------

// File: rtl/transform_scheduler.sv
// transform_scheduler: sequences the 4x4 blocks of a macroblock through a fixed-latency
// transform/quant/invquant/invtran datapath and tracks which block sits in each stage.
// Ports: clk, reset (async, active-low); mb_start/mb_abort in, mb_busy/mb_done out;
// res_valid in, res_ready/res_blk_idx out (residual source handshake);
// dp_enable out (enable for every datapath stage);
// out_valid/out_blk_idx out, out_ready in (reconstructed-block sink handshake);
// inflight out (number of valid pipeline slots).
module transform_scheduler #(
  parameter int PIPE_LAT = 4,
  parameter int BLOCKS   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mb_start,
  input  logic       mb_abort,
  output logic       mb_busy,
  output logic       mb_done,
  input  logic       res_valid,
  output logic       res_ready,
  output logic [3:0] res_blk_idx,
  output logic       dp_enable,
  output logic       out_valid,
  output logic [3:0] out_blk_idx,
  input  logic       out_ready,
  output logic [2:0] inflight
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [PIPE_LAT-1:0] vld;
  logic [PIPE_LAT-1:0][3:0] idx;
  logic [4:0] issued, retired;
  logic accept, retire;
  assign mb_busy     = state != IDLE;
  assign mb_done     = state == DONE;
  assign out_valid   = vld[PIPE_LAT-1];
  assign out_blk_idx = idx[PIPE_LAT-1];
  assign res_blk_idx = issued[3:0];
  // the whole datapath freezes while the tail holds a block the sink refuses
  assign dp_enable   = (state == RUN || state == DRAIN) && !(out_valid && !out_ready);
  assign res_ready   = state == RUN && issued < 5'(BLOCKS) && dp_enable;
  assign accept      = res_valid && res_ready;
  assign retire      = out_valid && out_ready;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) inflight = inflight + 3'(vld[i]);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      vld     <= '0;
      idx     <= '0;
      issued  <= '0;
      retired <= '0;
    end else if (mb_abort) begin
      state   <= IDLE;
      vld     <= '0;
      issued  <= '0;
      retired <= '0;
    end else begin
      // a cycle without an accept shifts a bubble into entry 0
      if (dp_enable) begin
        vld <= {vld[PIPE_LAT-2:0], accept};
        idx <= {idx[PIPE_LAT-2:0], res_blk_idx};
      end
      if (accept) issued <= issued + 5'd1;
      if (retire) retired <= retired + 5'd1;
      case (state)
        IDLE: if (mb_start) begin
          state   <= RUN;
          issued  <= '0;
          retired <= '0;
        end
        RUN:   if (accept && issued == 5'(BLOCKS - 1)) state <= DRAIN;
        DRAIN: if (retire && retired == 5'(BLOCKS - 1)) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
